// File: rtl/sg_s2mm_dma.sv
// sg_s2mm_dma: receive-side scatter-gather DMA, link stream -> AXI4 write bursts.
// One descriptor at a time, one burst outstanding, bursts never cross 4 KB.
module sg_s2mm_dma #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    desc_valid,
    input  logic [ADDR_WIDTH-1:0]   desc_addr,
    input  logic [LEN_WIDTH-1:0]    desc_len,
    output logic                    desc_ready,
    output logic                    done,
    output logic                    error,
    output logic                    awvalid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    input  logic                    awready,
    output logic                    wvalid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    wready,
    input  logic                    bvalid,
    input  logic [1:0]              bresp,
    output logic                    bready,
    input  logic                    s_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    output logic                    s_tready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, ISSUE_AW, WRITE_DATA, WAIT_B, DONE} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  beats_rem;
    logic [7:0]            beat_cnt;
    logic                  err_flag;
    logic                  wr;
    logic [8:0]            burst;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  next_rem;

    // min(remaining, 256, beats left before the next 4 KB boundary)
    function automatic logic [8:0] burst_of(input logic [11:0] a, input logic [LEN_WIDTH-1:0] r);
        logic [31:0] to_4k;
        logic [31:0] n;
        to_4k = (32'd4096 - {20'd0, a}) >> BSH;
        n = 32'(r);
        n = n > 32'd256 ? 32'd256 : n;
        return n > to_4k ? to_4k[8:0] : n[8:0];
    endfunction

    assign wr         = state == WRITE_DATA;
    assign burst      = {1'b0, awlen} + 9'd1;
    assign start_addr = desc_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign next_addr  = awaddr + (ADDR_WIDTH'(burst) << BSH);
    assign next_rem   = beats_rem - LEN_WIDTH'(burst);
    assign wvalid     = wr && s_tvalid;
    assign wdata      = wr ? s_tdata : '0;
    assign s_tready   = wr && wready;
    assign wlast      = wr && beat_cnt == awlen;
    assign wstrb      = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            desc_ready <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            awlen      <= '0;
            bready     <= 1'b0;
            beats_rem  <= '0;
            beat_cnt   <= '0;
            err_flag   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (desc_valid && desc_ready) begin
                        desc_ready <= 1'b0;
                        awaddr     <= start_addr;
                        beats_rem  <= desc_len;
                        err_flag   <= 1'b0;
                        awlen      <= 8'(burst_of(start_addr[11:0], desc_len) - 9'd1);
                        awvalid    <= desc_len != '0;
                        state      <= desc_len == '0 ? DONE : ISSUE_AW;
                    end else begin
                        desc_ready <= 1'b1;
                    end
                end
                ISSUE_AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (s_tvalid && wready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (wlast) begin
                            bready <= 1'b1;
                            state  <= WAIT_B;
                        end
                    end
                end
                WAIT_B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        err_flag  <= err_flag | (bresp != 2'b00);
                        beats_rem <= next_rem;
                        awaddr    <= next_addr;
                        if (next_rem == '0) begin
                            state <= DONE;
                        end else begin
                            awlen   <= 8'(burst_of(next_addr[11:0], next_rem) - 9'd1);
                            awvalid <= 1'b1;
                            state   <= ISSUE_AW;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    error      <= err_flag;
                    desc_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sg_s2mm_dma.sv
// tb_sg_s2mm_dma: randomized bench for sg_s2mm_dma against a burst-splitting reference model.
module tb_sg_s2mm_dma;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int BY = DW / 8;

    logic          clk, rst_n;
    logic          desc_valid, desc_ready, done, error;
    logic [AW-1:0] desc_addr;
    logic [LW-1:0] desc_len;
    logic          awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [DW-1:0] wdata, s_tdata;
    logic [BY-1:0] wstrb;
    logic [1:0]    bresp;
    logic          s_tvalid, s_tready;

    sg_s2mm_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_addr(desc_addr), .desc_len(desc_len), .desc_ready(desc_ready),
        .done(done), .error(error),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0]        src[$];
    logic [DW-1:0]        sent[$];
    logic [DW-1:0]        got_w[$];
    logic [AW-1:0]        got_aw_addr[$];
    logic [7:0]           got_aw_len[$];
    logic [1:0]           resp_plan[$];
    longint unsigned      exp_addr[$];
    int                   exp_len[$];
    int                   wlast_cnt, done_cnt, b_pend;
    bit                   aw_seen, gaps;
    bit                   s_hs, b_hs, w_last_hs, aw_wait;
    logic [AW-1:0]        aw_prev_addr;
    logic [7:0]           aw_prev_len;

    // Observe handshakes at negedge; they complete on the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_hs = 0; b_hs = 0; w_last_hs = 0; aw_wait = 0;
        end else begin
            if (aw_wait) check("aw_stable", {awvalid, awaddr, awlen}, {1'b1, aw_prev_addr, aw_prev_len});
            aw_wait = awvalid && !awready;
            aw_prev_addr = awaddr;
            aw_prev_len = awlen;
            if (awvalid) aw_seen = 1;
            if (awvalid && awready) begin
                got_aw_addr.push_back(awaddr);
                got_aw_len.push_back(awlen);
            end
            s_hs = s_tvalid && s_tready;
            if (s_hs || (wvalid && wready)) check("w_pass", {wvalid && wready, wdata}, {s_hs, s_tdata});
            if (wvalid && wready) begin
                got_w.push_back(wdata);
                if (wlast) wlast_cnt++;
            end
            w_last_hs = wvalid && wready && wlast;
            if (awvalid || bready) check("stream_stall", {s_tready, wvalid}, 2'b00);
            b_hs = bvalid && bready;
            if (done) done_cnt++;
        end
    end

    // Memory-side and link-side responder with optional random gaps.
    initial begin
        s_tvalid = 0; s_tdata = '0; awready = 0; wready = 0; bvalid = 0; bresp = 0; b_pend = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                src.delete();
                s_tvalid = 0; bvalid = 0; b_pend = 0; awready = 0; wready = 0;
                continue;
            end
            if (s_hs) void'(src.pop_front());
            if (!(s_tvalid && !s_hs)) s_tvalid = src.size() > 0 && (!gaps || $urandom_range(3) != 0);
            s_tdata = src.size() > 0 ? src[0] : '0;
            awready = !gaps || $urandom_range(2) != 0;
            wready = !gaps || $urandom_range(2) != 0;
            if (w_last_hs) b_pend++;
            if (b_hs) bvalid = 0;
            if (!bvalid && b_pend > 0 && (!gaps || $urandom_range(2) == 0)) begin
                bvalid = 1;
                b_pend--;
                bresp = resp_plan.size() > 0 ? resp_plan.pop_front() : 2'b00;
            end
        end
    end

    task automatic model(input logic [AW-1:0] addr, input int len);
        longint unsigned a;
        int rem, b, t;
        a = addr & ~64'(BY - 1);
        rem = len;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            b = rem > 256 ? 256 : rem;
            t = (4096 - int'(a % 4096)) / BY;
            if (b > t) b = t;
            exp_addr.push_back(a);
            exp_len.push_back(b - 1);
            a += longint'(b * BY);
            rem -= b;
        end
    endtask

    task automatic offer(input logic [AW-1:0] addr, input int len);
        int to;
        to = 0;
        @(negedge clk);
        while (!desc_ready && to < 200) begin
            @(negedge clk);
            to++;
        end
        check("desc_ready_wait", desc_ready, 1'b1);
        desc_valid = 1;
        desc_addr = addr;
        desc_len = LW'(len);
        @(posedge clk);
        #1 desc_valid = 0;
    endtask

    // mode 0: all OKAY, 1: first burst SLVERR, 2: random responses
    task automatic run_desc(input logic [AW-1:0] addr, input int len, input int mode);
        bit exp_err;
        logic [1:0] r;
        logic [DW-1:0] d;
        int cyc;
        model(addr, len);
        got_w.delete(); got_aw_addr.delete(); got_aw_len.delete(); sent.delete(); resp_plan.delete();
        wlast_cnt = 0;
        exp_err = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            r = mode == 1 ? (i == 0 ? 2'b10 : 2'b00) :
                mode == 2 ? ($urandom_range(3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00) : 2'b00;
            resp_plan.push_back(r);
            exp_err |= r != 2'b00;
        end
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            src.push_back(d);
            sent.push_back(d);
        end
        offer(addr, len);
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1'b1);
        check("error", error, exp_err);
        @(negedge clk);
        check("done_pulse", {done, error}, 2'b00);
        check("n_bursts", got_aw_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_aw_addr.size(); i++) begin
            check("aw_addr", got_aw_addr[i], exp_addr[i]);
            check("aw_len", got_aw_len[i], exp_len[i]);
        end
        check("n_beats", got_w.size(), len);
        for (int i = 0; i < len && i < got_w.size(); i++) check("w_data", got_w[i], sent[i]);
        check("wlast_cnt", wlast_cnt, exp_addr.size());
    endtask

    initial begin
        int dc, to;
        rst_n = 0; desc_valid = 0; desc_addr = '0; desc_len = '0; gaps = 0;
        repeat (3) @(negedge clk);
        check("rst_outs", {desc_ready, done, error, awvalid, wvalid, s_tready, bready, wlast}, 8'h00);
        check("rst_aw", {awaddr, awlen}, '0);
        rst_n = 1;
        @(negedge clk);
        check("ready_after_rst", desc_ready, 1'b1);

        run_desc(64'h1000, 4, 0);
        run_desc(64'hFE5, 8, 0);
        run_desc(64'h0, 300, 0);
        run_desc(64'hE00, 100, 1);
        run_desc(64'h3000, 10, 0);
        run_desc(64'hFFFF_FFFF_FFFF_FFF0, 4, 0);

        // zero-length descriptor: done exactly two cycles after accept, no AW
        aw_seen = 0;
        offer(64'h2000, 0);
        @(negedge clk);
        check("len0_c1", done, 1'b0);
        @(negedge clk);
        check("len0_c2", {done, error}, 2'b10);
        @(negedge clk);
        check("len0_c3", done, 1'b0);
        check("len0_no_aw", aw_seen, 1'b0);

        gaps = 1;
        for (int n = 0; n < 12; n++)
            run_desc({50'd0, 14'($urandom_range(0, 16383))}, $urandom_range(1, 400), 2);

        // reset in the middle of a write burst
        gaps = 0;
        got_w.delete();
        for (int i = 0; i < 40; i++) src.push_back({$urandom, $urandom});
        offer(64'h2000, 40);
        to = 0;
        while (got_w.size() < 5 && to < 200) begin
            @(negedge clk);
            to++;
        end
        check("mid_write_reached", got_w.size() >= 5, 1'b1);
        dc = done_cnt;
        rst_n = 0;
        #1;
        check("midrst_outs", {desc_ready, done, error, awvalid, wvalid, s_tready, bready, wlast}, 8'h00);
        check("midrst_aw", {awaddr, awlen}, '0);
        resp_plan.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("midrst_ready", desc_ready, 1'b1);
        check("midrst_no_done", done_cnt, dc);
        run_desc(64'h5040, 20, 0);
        check("wstrb", wstrb, {BY{1'b1}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
